// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch controller: FSM states, word size,
// and the prefetch queue entry layout.
package fetch_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding prefetched {pc, ins} pairs; supports flush and
// simultaneous push+pop while full.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(QDEPTH);

    fetch_entry_t  mem [QDEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // When full, the slot being written is the one being popped this cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < QDEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/ins_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, drives the instruction memory
// address and feeds decode from a prefetch queue over valid/ready.
module ins_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 16384,
    parameter int          QDEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        halt_req,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    output logic        running,
    output logic        halted,
    output logic        align_err,
    output logic [31:0] fetch_cnt
);

    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q;
    logic         in_range;
    logic         pop;
    logic         push;
    logic         q_full;
    logic         q_empty;
    fetch_entry_t q_head;
    fetch_entry_t q_wdata;

    assign in_range  = {2'b00, pc_q[31:2]} < MEM_WORDS_W;
    assign ins_valid = !q_empty;
    assign pop       = ins_valid && ins_ready;
    assign push      = (state_q == ST_RUN) && in_range && !redirect_valid && (!q_full || pop);
    assign q_wdata   = '{pc: pc_q, ins: mem_rdata};

    assign mem_addr  = pc_q;
    assign ins       = q_head.ins;
    assign ins_pc    = q_head.pc;
    assign running   = (state_q == ST_RUN);
    assign halted    = (state_q == ST_HALT);

    fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (q_wdata),
        .pop       (pop),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty)
    );

    // halt_req beats start; a restart from HALT needs an in-range PC.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start && !halt_req) state_d = ST_RUN;
            ST_RUN:  if (halt_req || !in_range) state_d = ST_HALT;
            ST_HALT: if (start && !halt_req && in_range) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            fetch_cnt <= '0;
            align_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            align_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (redirect_valid) begin
                pc_q <= {redirect_pc[31:2], 2'b00};
            end else if (push) begin
                pc_q      <= pc_q + 32'(WORD_BYTES);
                fetch_cnt <= fetch_cnt + 32'd1;
            end
        end
    end

endmodule

// File: doc/ins_fetch_ctrl.md
# ins_fetch_ctrl

Sequences the instruction memory: holds the fetch PC, drives the memory's byte address, captures the combinationally-read word into a small prefetch queue, and hands instructions to decode over a valid/ready handshake. Sits between the control unit (start, halt, branch/jump redirect) and `insMem`, which is an asynchronous-read, word-addressed array indexed by `pc >> 2`. It is the only block that drives the instruction memory address.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: fetch PC loaded on reset.
- `MEM_WORDS`, 16384: instruction memory depth in 32-bit words; fetch PC word index must be < this.
- `QDEPTH`, 2: prefetch queue entries (power of two, ≥2).

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  pulse; leave IDLE/HALT and begin fetching.
- `halt_req`  in  1  pulse; stop issuing new fetches.
- `redirect_valid`  in  1  branch/jump taken this cycle.
- `redirect_pc`  in  32  byte target; bits [1:0] ignored.
- `mem_addr`  out  32  byte address to `insMem.pc`.
- `mem_rdata`  in  32  `insMem.ins`, valid same cycle as `mem_addr`.
- `ins_valid`  out  1  queue head valid.
- `ins_ready`  in  1  decode accepts head.
- `ins`  out  32  head instruction word.
- `ins_pc`  out  32  head byte PC.
- `running`  out  1  FSM in RUN.
- `halted`  out  1  FSM in HALT.
- `align_err`  out  1  one-cycle pulse: redirect with nonzero [1:0].
- `fetch_cnt`  out  32  instructions pushed since reset; wraps.

## Operation
- FSM states: IDLE (reset state), RUN, HALT.
  - IDLE → RUN on `start`. RUN → HALT on `halt_req`, or when fetch PC word index ≥ `MEM_WORDS` (checked before push; out-of-range word never pushed). HALT → RUN on `start` only if fetch PC in range; otherwise stays HALT.
- `mem_addr` = fetch PC register, always driven (all states).
- Push condition (RUN only): PC in range, no redirect this cycle, and queue not full or a pop occurs this cycle. Push writes {fetch PC, `mem_rdata`}, fetch PC += 4, `fetch_cnt` += 1.
- Pop: `ins_valid && ins_ready`. Queue drains in all states, including HALT and IDLE.
- Redirect (any state, highest priority): queue flushed, fetch PC ← {`redirect_pc`[31:2], 2'b00}, no push that cycle. A pop in the same cycle completes normally (decode consumed it) before the flush. Redirect does not change FSM state; in HALT it sets the PC for a later `start`.
- `halt_req` and `start` together: `halt_req` wins. `halt_req` with redirect: both take effect.
- PC increment wraps modulo 2^32; range check catches it first for `MEM_WORDS` < 2^30.
- Zero instruction words are passed through unchanged.

## Timing
- Reset (async assert, sync-safe release): state IDLE, fetch PC = `RESET_PC`, queue empty, `ins_valid`=0, `ins`=0, `ins_pc`=0, `running`=0, `halted`=0, `align_err`=0, `fetch_cnt`=0. Reset mid-run discards queue contents immediately.
- `start` in cycle N → `running`=1 in N+1; first push at end of N+1; `ins_valid`=1 in N+2 with `ins_pc`=`RESET_PC`.
- Fetch-to-output latency: 1 cycle. Sustained throughput: one instruction/cycle with `ins_ready` held high.
- Redirect in cycle N → `ins_valid`=0 in N+1, target word valid in N+2.
- `ins`, `ins_pc`, `ins_valid` are registered/queue outputs; stable while `ins_valid && !ins_ready`.
- `align_err` asserted in cycle N+1 for one cycle.

## Structure
- Shared package `fetch_pkg`: FSM state enum (IDLE/RUN/HALT), `WORD_BYTES`=4, queue entry typedef {pc[31:0], ins[31:0]}.
- One sub-module: `fetch_queue`, a QDEPTH-entry synchronous FIFO with flush, push/pop, full/empty, simultaneous push+pop when full.

## Test plan
- Reset, `start`, `ins_ready`=1, memory words 0..3 = 0x11,0x22,0x33,0x44 → `ins`/`ins_pc` = 0x11/0x0, 0x22/0x4, 0x33/0x8, 0x44/0xC on consecutive cycles starting 2 cycles after `start`; `fetch_cnt`=4.
- `ins_ready`=0 for 5 cycles while running → exactly QDEPTH pushes, `mem_addr` frozen at 0x8, head held at pc 0x0; release → ordered stream resumes with no gaps or duplicates.
- Redirect to 0x40 while queue holds 0x8, 0xC → next `ins_valid` is pc 0x40, old entries never appear.
- Redirect to 0x43 → fetches from 0x40, `align_err` pulses one cycle.
- Redirect to (`MEM_WORDS`−1)*4 → that word delivered, then `halted`=1, no further pushes; `start` keeps HALT; redirect to 0x0 then `start` → RUN, pc 0x0 delivered.
- `rst_n` dropped mid-stream with full queue → outputs immediately at reset values; after release and `start`, fetch begins at `RESET_PC`.
